// File: rtl/conv_k_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : conv_k_mem_reader
// Purpose  : Multi-lane read-address sequencer for convolution kernel-weight
//            memories. NKERN kernels of KSIZE words are split evenly across
//            LANES read ports; every lane sweeps its own SPAN-word slice in
//            lockstep. The sweep is repeated npass times (one per output
//            pixel) with no bubble between passes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W  width of each lane address
//   KSIZE   words per kernel
//   NKERN   kernels held in memory
//   LANES   parallel read ports (NKERN must be a multiple of LANES)
//   PASS_W  width of the pass-count input
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   begin a sequence (only looked at while idle)
//   en         in   advance enable; low stalls and holds the address
//   base_addr  in   memory base, captured when start is accepted
//   npass      in   number of sweeps, captured on start; 0 behaves as 1
//   addr       out  lane i at [i*ADDR_W +: ADDR_W], registered
//   valid      out  addr is a live read this cycle
//   busy       out  sequencer is running or signalling done
//   done       out  one-cycle pulse after the final address
//   k_last     out  last word of a kernel (only with CONV_KREAD_KLAST_EN)
// Configuration macro
//   CONV_KREAD_KLAST_EN  adds the k_last port and its per-lane subcounters
// ============================================================================
module conv_k_mem_reader #(
  parameter int ADDR_W = 8,
  parameter int KSIZE  = 25,
  parameter int NKERN  = 6,
  parameter int LANES  = 2,
  parameter int PASS_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [PASS_W-1:0]       npass,
  output logic [LANES*ADDR_W-1:0] addr,
  output logic                    valid,
  output logic                    busy,
`ifdef CONV_KREAD_KLAST_EN
  output logic                    done,
  output logic                    k_last
`else
  output logic                    done
`endif
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int KPL   = NKERN / LANES;      // kernels per lane
  localparam int SPAN  = KPL * KSIZE;        // words swept per lane per pass
  localparam int OFF_W = (SPAN > 1) ? $clog2(SPAN) : 1;

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SPAN - 1);

  generate
    if ((LANES < 1) || ((NKERN % LANES) != 0)) begin : g_bad_lanes
      $error("conv_k_mem_reader: NKERN (%0d) must be a multiple of LANES (%0d)",
             NKERN, LANES);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [PASS_W-1:0]       npass_q, npass_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [LANES*ADDR_W-1:0] addr_q, addr_d;

  // --------------------------------------------------------------------------
  // Control decodes shared by the FSM and the datapath
  // --------------------------------------------------------------------------
  logic              w_accept;     // start taken this cycle
  logic              w_step;       // offset advances this cycle
  logic              w_off_end;    // sitting on the last word of the slice
  logic              w_last_pass;  // current pass is the final one
  logic              w_finish;     // final address consumed
  logic              w_addr_upd;   // address register loads a new value
  logic [ADDR_W-1:0] w_base_sel;   // base used for the next address

  assign w_accept    = (state_q == S_IDLE) && start;
  assign w_step      = (state_q == S_RUN) && en;
  assign w_off_end   = (off_q == OFF_LAST);
  // npass_q is never 0 once latched, so npass_q-1 cannot underflow in RUN
  assign w_last_pass = (pass_q == (npass_q - PASS_W'(1)));
  assign w_finish    = w_step && w_off_end && w_last_pass;
  // On the final step the address is left alone so it holds into DONE/IDLE
  assign w_addr_upd  = w_accept || (w_step && !w_finish);
  assign w_base_sel  = w_accept ? base_addr : base_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // valid follows en combinationally so a stall drops it in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_RUN: begin
        valid = en;
        busy  = 1'b1;
      end
      S_DONE: begin
        busy  = 1'b1;
        done  = 1'b1;
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Offset / pass counters and latched configuration
  // --------------------------------------------------------------------------
  always_comb begin
    base_d  = base_q;
    npass_d = npass_q;
    off_d   = off_q;
    pass_d  = pass_q;
    if (w_accept) begin
      base_d  = base_addr;
      npass_d = (npass == '0) ? PASS_W'(1) : npass;
      off_d   = '0;
      pass_d  = '0;
    end else if (w_step) begin
      if (w_off_end) begin
        // wrap straight into the next pass with no idle cycle
        off_d = '0;
        if (!w_last_pass) begin
          pass_d = pass_q + PASS_W'(1);
        end
      end else begin
        off_d = off_q + OFF_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane address: base + lane*SPAN + offset, wrapping in ADDR_W bits.
  // Built from off_d so the register already shows the next word.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic [ADDR_W-1:0] LANE_BASE = ADDR_W'(g * SPAN);

    assign addr_d[g*ADDR_W +: ADDR_W] = w_addr_upd
        ? (w_base_sel + LANE_BASE + ADDR_W'(off_d))
        : addr_q[g*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      npass_q <= '0;
      pass_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
    end else begin
      base_q  <= base_d;
      npass_q <= npass_d;
      pass_q  <= pass_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
    end
  end

  assign addr = addr_q;

`ifdef CONV_KREAD_KLAST_EN
  // --------------------------------------------------------------------------
  // Kernel-boundary flag. A mod-KSIZE subcounter per lane avoids a divider;
  // lanes move in lockstep, so the flags are AND-ed into one output.
  // --------------------------------------------------------------------------
  localparam int               KC_W    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam logic [KC_W-1:0]  KC_LAST = KC_W'(KSIZE - 1);

  logic [LANES-1:0] lane_klast;

  for (genvar g = 0; g < LANES; g++) begin : g_kcnt
    logic [KC_W-1:0] kcnt_q, kcnt_d;

    always_comb begin
      kcnt_d = kcnt_q;
      if (w_accept) begin
        kcnt_d = '0;
      end else if (w_step) begin
        // slice end always coincides with a kernel end, wrap there too
        kcnt_d = (w_off_end || (kcnt_q == KC_LAST)) ? '0 : (kcnt_q + KC_W'(1));
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        kcnt_q <= '0;
      end else begin
        kcnt_q <= kcnt_d;
      end
    end

    assign lane_klast[g] = (kcnt_q == KC_LAST);
  end

  assign k_last = valid && (&lane_klast);
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_k_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_k_mem_reader
// Purpose  : Self-checking bench for conv_k_mem_reader. Two instances: the
//            default 2-lane geometry (A) and a 3-lane, 9-word-kernel one (B).
//            Every live address is compared with a queue of expected offsets
//            built from the lane/offset arithmetic of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_k_mem_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, en;
  logic [7:0]  base_addr;
  logic [9:0]  npass;
  logic [15:0] addr_a;
  logic [23:0] addr_b;
  logic        valid_a, busy_a, done_a;
  logic        valid_b, busy_b, done_b;
`ifdef CONV_KREAD_KLAST_EN
  logic        k_last_a, k_last_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_k_mem_reader u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .en        (en),
    .base_addr (base_addr),
    .npass     (npass),
    .addr      (addr_a),
    .valid     (valid_a),
    .busy      (busy_a),
`ifdef CONV_KREAD_KLAST_EN
    .done      (done_a),
    .k_last    (k_last_a)
`else
    .done      (done_a)
`endif
  );

  conv_k_mem_reader #(
    .ADDR_W (8),
    .KSIZE  (9),
    .NKERN  (6),
    .LANES  (3),
    .PASS_W (10)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .en        (en),
    .base_addr (base_addr),
    .npass     (npass),
    .addr      (addr_b),
    .valid     (valid_b),
    .busy      (busy_b),
`ifdef CONV_KREAD_KLAST_EN
    .done      (done_b),
    .k_last    (k_last_b)
`else
    .done      (done_b)
`endif
  );

  // Observation mux: sel picks which instance the current sequence watches
  bit          sel = 1'b0;
  logic [23:0] m_addr;
  logic        m_valid, m_busy, m_done;
  assign m_addr  = sel ? addr_b  : {8'h00, addr_a};
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
`ifdef CONV_KREAD_KLAST_EN
  logic m_klast;
  assign m_klast = sel ? k_last_b : k_last_a;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane i reads base + i*span + off, modulo 256
  function automatic logic [23:0] model_addr(input int b, input int span,
                                             input int lanes, input int off);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      r[i*8 +: 8] = 8'((b + i * span + off) % 256);
    end
    return r;
  endfunction

  // One full start..done..idle sequence on the selected instance.
  // mode: 0 = en always 1, 1 = en 0/1 alternating (starting 0), 2 = random 60%
  task automatic run_seq(input bit s, input logic [7:0] b, input logic [9:0] np,
                         input int mode, input bit mid_start,
                         output logic [23:0] first_a, output logic [23:0] last_a,
                         output int nvalid, output int nrun);
    int          q[$];
    int          span, lanes, ks, npe, cyc, off;
    logic [23:0] exp_addr;
    sel   = s;
    span  = s ? 18 : 75;
    lanes = s ? 3 : 2;
    ks    = s ? 9 : 25;
    npe   = (np == 0) ? 1 : int'(np);
    for (int p = 0; p < npe; p++) begin
      for (int o = 0; o < span; o++) q.push_back(o);
    end
    nvalid  = 0;
    nrun    = 0;
    first_a = '0;
    last_a  = '0;

    @(negedge clk);
    base_addr = b;
    npass     = np;
    en        = 1'b0;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;

    cyc = 0;
    while ((q.size() > 0) && (cyc < 4000)) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        0:       en = 1'b1;
        1:       en = ((cyc % 2) == 1);
        default: en = ($urandom_range(99) < 60);
      endcase
      if (mid_start && ($urandom_range(3) == 0)) begin
        base_addr = 8'($urandom);
        npass     = 10'($urandom);
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      #1;
      nrun++;
      exp_addr = model_addr(int'(b), span, lanes, q[0]);
      chk("run_busy", m_busy, 1);
      chk("run_done", m_done, 0);
      chk("run_valid", m_valid, en);
      chk("run_addr", m_addr, exp_addr);
      if (en) begin
        off = q.pop_front();
`ifdef CONV_KREAD_KLAST_EN
        chk("klast_live", m_klast, ((off % ks) == ks - 1));
`endif
        nvalid++;
        if (nvalid == 1) first_a = m_addr;
        last_a = m_addr;
      end else begin
`ifdef CONV_KREAD_KLAST_EN
        chk("klast_stall", m_klast, 0);
`endif
      end
      cyc++;
    end
    chk("run_budget", q.size(), 0);

    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    en      = 1'($urandom);
    #1;
    chk("done_pulse", m_done, 1);
    chk("done_valid", m_valid, 0);
    chk("done_busy", m_busy, 1);
    chk("done_addr", m_addr, model_addr(int'(b), span, lanes, span - 1));
`ifdef CONV_KREAD_KLAST_EN
    chk("done_klast", m_klast, 0);
`endif
    @(negedge clk);
    #1;
    chk("idle_done", m_done, 0);
    chk("idle_busy", m_busy, 0);
    chk("idle_valid", m_valid, 0);
    chk("idle_addr", m_addr, model_addr(int'(b), span, lanes, span - 1));
  endtask

  typedef struct {
    bit          s;
    logic [7:0]  b;
    logic [9:0]  np;
    int          mode;
    bit          mid;
    logic [23:0] first;
    logic [23:0] last;
    int          nvalid;
    int          nrun;     // -1: not fixed (random enable)
  } vec_t;

  initial begin : g_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    vec_t        vt[8];
    logic [23:0] f, l;
    int          nv, nr, npe, span;
    bit          rs;
    logic [7:0]  rb;
    logic [9:0]  rn;

    vt[0] = '{1'b0, 8'd0,   10'd1, 0, 1'b0, 24'h004B00, 24'h00954A, 75,  75};
    vt[1] = '{1'b0, 8'd0,   10'd1, 1, 1'b0, 24'h004B00, 24'h00954A, 75,  150};
    vt[2] = '{1'b0, 8'd0,   10'd3, 0, 1'b0, 24'h004B00, 24'h00954A, 225, 225};
    vt[3] = '{1'b0, 8'd0,   10'd0, 0, 1'b0, 24'h004B00, 24'h00954A, 75,  75};
    vt[4] = '{1'b1, 8'd100, 10'd1, 0, 1'b1, 24'h887664, 24'h998775, 18,  18};
    vt[5] = '{1'b0, 8'd200, 10'd1, 2, 1'b1, 24'h0013C8, 24'h005D12, 75,  -1};
    vt[6] = '{1'b0, 8'd10,  10'd2, 2, 1'b0, 24'h00550A, 24'h009F54, 150, -1};
    vt[7] = '{1'b1, 8'd250, 10'd2, 1, 1'b1, 24'h1E0CFA, 24'h2F1D0B, 36,  72};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; en = 1'b0;
    base_addr = '0; npass = '0;
    #1;
    chk("rst_addr_a", {8'h00, addr_a}, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_flags", {valid_a, busy_a, done_a, valid_b, busy_b, done_b}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_busy", {busy_a, busy_b}, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_seq(vt[i].s, vt[i].b, vt[i].np, vt[i].mode, vt[i].mid, f, l, nv, nr);
      chk($sformatf("vec%0d_first", i), f, vt[i].first);
      chk($sformatf("vec%0d_last", i), l, vt[i].last);
      chk($sformatf("vec%0d_nvalid", i), nv, vt[i].nvalid);
      if (vt[i].nrun >= 0) chk($sformatf("vec%0d_nrun", i), nr, vt[i].nrun);
    end

    // Asynchronous reset in the middle of a sweep, at offset 30
    sel = 1'b0;
    @(negedge clk);
    base_addr = 8'd0; npass = 10'd1; en = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 30; c++) @(negedge clk);
    #1;
    chk("pre_rst_addr", m_addr, model_addr(0, 75, 2, 30));
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", m_addr, 0);
    chk("mid_rst_flags", {m_valid, m_busy, m_done}, 0);
`ifdef CONV_KREAD_KLAST_EN
    chk("mid_rst_klast", m_klast, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    run_seq(1'b0, 8'd0, 10'd1, 0, 1'b0, f, l, nv, nr);
    chk("restart_first", f, 24'h004B00);
    chk("restart_nvalid", nv, 75);

    // Randomised sequences against the model
    for (int r = 0; r < 6; r++) begin
      rs   = 1'($urandom);
      rb   = 8'($urandom);
      rn   = 10'($urandom_range(3));
      span = rs ? 18 : 75;
      npe  = (rn == 0) ? 1 : int'(rn);
      run_seq(rs, rb, rn, int'($urandom_range(2)), 1'($urandom), f, l, nv, nr);
      chk($sformatf("rand%0d_nvalid", r), nv, npe * span);
      chk($sformatf("rand%0d_first", r), f, model_addr(int'(rb), span, rs ? 3 : 2, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
